// File: rtl/rr_mux4_if.sv
// rr_mux4_if: four valid/ready input channels plus one tagged output stream.
// Ports: a..d valid/data/ready, out_valid/out_data/out_sel/out_ready.
interface rr_mux4_if #(
   parameter int WIDTH = 8
);
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;
   logic             c_valid;
   logic [WIDTH-1:0] c_data;
   logic             c_ready;
   logic             d_valid;
   logic [WIDTH-1:0] d_data;
   logic             d_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_sel;
   logic             out_ready;

   modport slave (
      input  a_valid, a_data,
      input  b_valid, b_data,
      input  c_valid, c_data,
      input  d_valid, d_data,
      output a_ready, b_ready,
      output c_ready, d_ready,
      output out_valid, out_data,
      output out_sel,
      input  out_ready
   );

   modport master (
      output a_valid, a_data,
      output b_valid, b_data,
      output c_valid, c_data,
      output d_valid, d_data,
      input  a_ready, b_ready,
      input  c_ready, d_ready,
      input  out_valid, out_data,
      input  out_sel,
      output out_ready
   );
endinterface

// File: rtl/rr_mux4.sv
// rr_mux4: round-robin 4:1 stream mux into a registered, source-tagged output.
// Ports: clk, rst (sync, active-high), bus (rr_mux4_if.slave).
module rr_mux4 #(
   parameter int WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   rr_mux4_if.slave  bus
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       ptr_q, ptr_d;

   logic [3:0]       vld;
   logic [3:0]       rdy;
   logic [1:0]       idx;
   logic [1:0]       gnt_idx;
   logic             gnt_any;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] gnt_data;

   assign vld = {bus.d_valid, bus.c_valid,
                 bus.b_valid, bus.a_valid};

   // First valid channel scanning upward from ptr.
   always_comb begin
      idx     = ptr_q;
      gnt_any = 1'b0;
      gnt_idx = ptr_q;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!gnt_any && vld[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign load = !rst &&
                 (state_q == EMPTY || bus.out_ready);
   assign xfer = gnt_any && load;
   assign rdy  = xfer ? (4'b0001 << gnt_idx) : 4'b0000;

   always_comb begin
      gnt_data = bus.a_data;
      unique case (gnt_idx)
         2'd0: gnt_data = bus.a_data;
         2'd1: gnt_data = bus.b_data;
         2'd2: gnt_data = bus.c_data;
         2'd3: gnt_data = bus.d_data;
         default: gnt_data = bus.a_data;
      endcase
   end

   // A free or draining register with no grant goes empty.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         state_d = FULL;
         data_d  = gnt_data;
         sel_d   = gnt_idx;
         ptr_d   = gnt_idx + 2'd1;
      end else if (load) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.a_ready   = rdy[0];
   assign bus.b_ready   = rdy[1];
   assign bus.c_ready   = rdy[2];
   assign bus.d_ready   = rdy[3];
   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
endmodule
